mp3_button_sequencer: RTL

Avalon-MM master that services the 4-button PIO (edge-capture, IRQ-capable) of the MP3 player without CPU involvement. After reset it programs the PIO interrupt mask. On each button IRQ it reads the edge-capture register and clears the serviced bits. It then converts each captured button into a player command code in a small FIFO, drained by the playback controller over a valid/ready handshake.

---
 rtl/mp3_button_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mp3_button_sequencer.sv
// Avalon-MM master that services the MP3 player's 4-button edge-capture PIO and
// turns each captured button into a command code in a small FWFT FIFO.
module mp3_button_sequencer #(
    parameter logic [3:0]  MASK_INIT  = 4'hF,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        cfg_mask_wr,
    input  logic [3:0]  cfg_mask,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata,
    input  logic        pio_irq,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_code,
    output logic        overflow,
    input  logic        overflow_clr
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StInit, StIdle, StMaskWr, StRdAddr, StRdData, StClr, StPush
    } state_t;

    state_t        r_state, w_state_d;
    logic [3:0]    r_mask, r_cap, w_cap_d, w_cap_clr;
    logic          r_mask_pend, w_mask_pend_d;
    logic [1:0]    w_idx;
    logic [2:0]    w_push_code;
    logic          w_push, w_push_ok, w_pop, w_drop, w_bypass;
    logic          w_cs, w_wn;
    logic [1:0]    w_addr;
    logic [31:0]   w_wd;
    logic [2:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_d;
    logic [AW:0]   r_count, w_count_d;
    logic          r_cmd_valid, r_overflow;
    logic [2:0]    r_cmd_code, w_cmd_code_d;
    logic          w_unused_rd;

    assign w_unused_rd = ^pio_readdata[31:4];

    always_comb begin
        w_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_cap[i]) w_idx = 2'(i);
        end
    end
    assign w_push_code = {1'b0, w_idx} + 3'd1;
    assign w_cap_clr   = r_cap & ~(4'd1 << w_idx);

    always_comb begin
        w_state_d = r_state;
        w_cap_d   = r_cap;
        w_push    = 1'b0;
        w_cs      = 1'b0;
        w_wn      = 1'b1;
        w_addr    = 2'd0;
        w_wd      = 32'd0;
        case (r_state)
            StInit: begin
                w_cs      = 1'b1;
                w_wn      = 1'b0;
                w_addr    = 2'd2;
                w_wd      = {28'd0, MASK_INIT};
                w_state_d = StIdle;
            end
            StIdle: begin
                if (r_mask_pend)            w_state_d = StMaskWr;
                else if (enable && pio_irq) w_state_d = StRdAddr;
            end
            StMaskWr: begin
                w_cs      = 1'b1;
                w_wn      = 1'b0;
                w_addr    = 2'd2;
                w_wd      = {28'd0, r_mask};
                w_state_d = StIdle;
            end
            StRdAddr: begin
                w_cs      = 1'b1;
                w_addr    = 2'd3;
                w_state_d = StRdData;
            end
            StRdData: begin
                // Address held so the PIO's registered read data stays on the capture cycle
                w_cs      = 1'b1;
                w_addr    = 2'd3;
                w_cap_d   = pio_readdata[3:0];
                w_state_d = StClr;
            end
            StClr: begin
                w_cs      = 1'b1;
                w_wn      = 1'b0;
                w_addr    = 2'd3;
                w_wd      = {28'd0, r_cap};
                w_state_d = (r_cap == 4'd0) ? StIdle : StPush;
            end
            StPush: begin
                w_push    = 1'b1;
                w_cap_d   = w_cap_clr;
                w_state_d = (w_cap_clr == 4'd0) ? StIdle : StPush;
            end
            default: w_state_d = StInit;
        endcase
    end

    // Gated by reset so an access aborts the instant reset asserts, while the
    // INIT write is already on the bus in the first cycle after release.
    assign pio_chipselect = w_cs & reset_n;
    assign pio_write_n    = w_wn | ~reset_n;
    assign pio_address    = w_addr & {2{reset_n}};
    assign pio_writedata  = w_wd & {32{reset_n}};

    assign w_mask_pend_d = cfg_mask_wr ? 1'b1 : ((r_state == StMaskWr) ? 1'b0 : r_mask_pend);

    assign w_pop      = r_cmd_valid & cmd_ready;
    assign w_push_ok  = w_push & ((r_count < DEPTH_C) | w_pop);
    assign w_drop     = w_push & ~w_push_ok;
    assign w_count_d  = r_count + (AW + 1)'(w_push_ok) - (AW + 1)'(w_pop);
    assign w_rd_ptr_d = r_rd_ptr + AW'(w_pop);
    // The new head is the entry being pushed when the FIFO would otherwise be empty
    assign w_bypass   = w_push_ok & (r_count == (AW + 1)'(w_pop));

    always_comb begin
        w_cmd_code_d = 3'd0;
        if (w_bypass)               w_cmd_code_d = w_push_code;
        else if (w_count_d != '0)   w_cmd_code_d = r_mem[w_rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= w_push_code;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StInit;
            r_mask      <= MASK_INIT;
            r_mask_pend <= 1'b0;
            r_cap       <= 4'd0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_valid <= 1'b0;
            r_cmd_code  <= 3'd0;
            r_overflow  <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cap       <= w_cap_d;
            r_mask_pend <= w_mask_pend_d;
            if (cfg_mask_wr) r_mask <= cfg_mask;
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr    <= w_rd_ptr_d;
            r_count     <= w_count_d;
            r_cmd_valid <= (w_count_d != '0);
            r_cmd_code  <= w_cmd_code_d;
            if (w_drop)            r_overflow <= 1'b1;
            else if (overflow_clr) r_overflow <= 1'b0;
        end
    end

    assign cmd_valid = r_cmd_valid;
    assign cmd_code  = r_cmd_code;
    assign overflow  = r_overflow;

endmodule
